// File: rtl/uart_command_master.sv
`default_nettype none
// ============================================================================
// Module   : uart_command_master
// Purpose  : Serialises one register-file/ALU command into UART frame bytes,
//            then gathers the response bytes and reports them with one pulse.
// Revision : 1.0 - initial release
// ============================================================================
module uart_command_master #(
    parameter int DATA_WIDTH          = 8,
    parameter int REGISTER_FILE_DEPTH = 16,
    parameter int RESPONSE_TIMEOUT    = 4096
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic [1:0]                             cmd_type,
    input  logic [$clog2(REGISTER_FILE_DEPTH)-1:0] cmd_address,
    input  logic [DATA_WIDTH-1:0]                  cmd_data_a,
    input  logic [DATA_WIDTH-1:0]                  cmd_data_b,
    input  logic [3:0]                             cmd_function,
    output logic                                   tx_parallel_data_valid,
    output logic [DATA_WIDTH-1:0]                  tx_parallel_data,
    input  logic                                   tx_busy_sync,
    input  logic                                   rx_parallel_data_valid_sync,
    input  logic [DATA_WIDTH-1:0]                  rx_parallel_data_sync,
    output logic                                   rsp_valid,
    output logic [2*DATA_WIDTH-1:0]                rsp_data,
    output logic                                   rsp_timeout
);

    localparam int c_AW = $clog2(REGISTER_FILE_DEPTH);
    localparam int c_TW = $clog2(RESPONSE_TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(RESPONSE_TIMEOUT - 1);

    localparam logic [1:0] c_CMD_WRITE   = 2'd0;
    localparam logic [1:0] c_CMD_READ    = 2'd1;
    localparam logic [1:0] c_CMD_ALU_OPS = 2'd2;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_SEND     = 3'd1;
    localparam logic [2:0] c_ST_BUSY_HI  = 3'd2;
    localparam logic [2:0] c_ST_BUSY_LO  = 3'd3;
    localparam logic [2:0] c_ST_WAIT_RSP = 3'd4;
    localparam logic [2:0] c_ST_DONE     = 3'd5;

    logic [2:0]            r_state;
    logic [1:0]            r_type;
    logic [c_AW-1:0]       r_addr;
    logic [DATA_WIDTH-1:0] r_data_a;
    logic [DATA_WIDTH-1:0] r_data_b;
    logic [3:0]            r_func;
    logic [1:0]            r_byte_idx;
    logic                  r_rx_idx;
    logic [DATA_WIDTH-1:0] r_rsp_byte0;
    logic [c_TW-1:0]       r_timer;

    logic [DATA_WIDTH-1:0] w_frame_byte;
    logic [1:0]            w_last_idx;
    logic [1:0]            w_rsp_count;
    logic                  w_final_rx;

    always_comb begin
        w_frame_byte = '0;
        w_last_idx   = 2'd1;
        w_rsp_count  = 2'd2;
        case (r_type)
            c_CMD_WRITE: begin
                w_last_idx  = 2'd2;
                w_rsp_count = 2'd0;
                case (r_byte_idx)
                    2'd0:    w_frame_byte = DATA_WIDTH'(8'hAA);
                    2'd1:    w_frame_byte = DATA_WIDTH'(r_addr);
                    default: w_frame_byte = r_data_a;
                endcase
            end
            c_CMD_READ: begin
                w_rsp_count  = 2'd1;
                w_frame_byte = (r_byte_idx == 2'd0) ? DATA_WIDTH'(8'hBB) : DATA_WIDTH'(r_addr);
            end
            c_CMD_ALU_OPS: begin
                w_last_idx = 2'd3;
                case (r_byte_idx)
                    2'd0:    w_frame_byte = DATA_WIDTH'(8'hCC);
                    2'd1:    w_frame_byte = r_data_a;
                    2'd2:    w_frame_byte = r_data_b;
                    default: w_frame_byte = DATA_WIDTH'(r_func);
                endcase
            end
            default: begin
                w_frame_byte = (r_byte_idx == 2'd0) ? DATA_WIDTH'(8'hDD) : DATA_WIDTH'(r_func);
            end
        endcase
    end

    // A strobe that completes the response takes priority over timer expiry.
    assign w_final_rx = rx_parallel_data_valid_sync &&
                        (({1'b0, r_rx_idx} + 2'd1) == w_rsp_count);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state                <= c_ST_IDLE;
            r_type                 <= '0;
            r_addr                 <= '0;
            r_data_a               <= '0;
            r_data_b               <= '0;
            r_func                 <= '0;
            r_byte_idx             <= '0;
            r_rx_idx               <= 1'b0;
            r_rsp_byte0            <= '0;
            r_timer                <= '0;
            cmd_ready              <= 1'b1;
            tx_parallel_data_valid <= 1'b0;
            tx_parallel_data       <= '0;
            rsp_valid              <= 1'b0;
            rsp_data               <= '0;
            rsp_timeout            <= 1'b0;
        end else begin
            tx_parallel_data_valid <= 1'b0;
            rsp_valid              <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_valid) begin
                        r_type     <= cmd_type;
                        r_addr     <= cmd_address;
                        r_data_a   <= cmd_data_a;
                        r_data_b   <= cmd_data_b;
                        r_func     <= cmd_function;
                        r_byte_idx <= 2'd0;
                        cmd_ready  <= 1'b0;
                        r_state    <= c_ST_SEND;
                    end
                end
                c_ST_SEND: begin
                    if (!tx_busy_sync) begin
                        tx_parallel_data       <= w_frame_byte;
                        tx_parallel_data_valid <= 1'b1;
                        r_state                <= c_ST_BUSY_HI;
                    end
                end
                c_ST_BUSY_HI: begin
                    if (tx_busy_sync) r_state <= c_ST_BUSY_LO;
                end
                c_ST_BUSY_LO: begin
                    if (!tx_busy_sync) begin
                        if (r_byte_idx != w_last_idx) begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_state    <= c_ST_SEND;
                        end else if (w_rsp_count == 2'd0) begin
                            rsp_valid   <= 1'b1;
                            rsp_data    <= '0;
                            rsp_timeout <= 1'b0;
                            r_state     <= c_ST_DONE;
                        end else begin
                            r_timer  <= '0;
                            r_rx_idx <= 1'b0;
                            r_state  <= c_ST_WAIT_RSP;
                        end
                    end
                end
                c_ST_WAIT_RSP: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_final_rx) begin
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b0;
                        rsp_data    <= (w_rsp_count == 2'd1) ?
                                       {{DATA_WIDTH{1'b0}}, rx_parallel_data_sync} :
                                       {rx_parallel_data_sync, r_rsp_byte0};
                        r_state     <= c_ST_DONE;
                    end else begin
                        if (rx_parallel_data_valid_sync) begin
                            r_rsp_byte0 <= rx_parallel_data_sync;
                            r_rx_idx    <= 1'b1;
                        end
                        if (r_timer == c_TIMER_LAST) begin
                            rsp_valid   <= 1'b1;
                            rsp_timeout <= 1'b1;
                            rsp_data    <= '0;
                            r_state     <= c_ST_DONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    cmd_ready <= 1'b1;
                    r_state   <= c_ST_IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_command_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_command_master
// Purpose  : Directed self-checking bench for uart_command_master with a
//            10-cycle-per-byte transmitter model and scripted rx replies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_command_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [3:0]  cmd_address;
    logic [7:0]  cmd_data_a;
    logic [7:0]  cmd_data_b;
    logic [3:0]  cmd_function;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_timeout;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   fall_cyc = 0;
    int   n_busy_viol = 0;
    int   n_double = 0;
    int   n_rsp = 0;
    logic prev_tx_valid = 1'b0;
    logic [7:0] tx_q[$];

    logic [15:0] r_d;
    logic        r_to;
    int          r_cyc;
    int          rsp_before;
    int          target;

    uart_command_master #(
        .DATA_WIDTH(8),
        .REGISTER_FILE_DEPTH(16),
        .RESPONSE_TIMEOUT(32)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_type(cmd_type),
        .cmd_address(cmd_address),
        .cmd_data_a(cmd_data_a),
        .cmd_data_b(cmd_data_b),
        .cmd_function(cmd_function),
        .tx_parallel_data_valid(tx_valid),
        .tx_parallel_data(tx_data),
        .tx_busy_sync(tx_busy),
        .rx_parallel_data_valid_sync(rx_valid),
        .rx_parallel_data_sync(rx_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy for 10 cycles after each strobe; logs bytes.
    always @(negedge clk) begin
        if (tx_valid) begin
            if (tx_busy) n_busy_viol++;
            if (prev_tx_valid) n_double++;
            tx_q.push_back(tx_data);
            busy_cnt = 10;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) fall_cyc = cyc;
        end
        tx_busy = (busy_cnt != 0);
        prev_tx_valid = tx_valid;
        if (rsp_valid) n_rsp++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] da,
                         input logic [7:0] db, input logic [3:0] f);
        int k = 0;
        while (!cmd_ready && k < 100) begin
            tick();
            k++;
        end
        if (!cmd_ready) chk("cmd_ready_bound", 32'd0, 32'd1);
        cmd_type = t;
        cmd_address = a;
        cmd_data_a = da;
        cmd_data_b = db;
        cmd_function = f;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_txdone(input int n);
        int k = 0;
        while (!(tx_q.size() >= n && !tx_busy) && k < 500) begin
            tick();
            k++;
        end
        if (k >= 500) chk("txdone_bound", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(output logic [15:0] d, output logic to, output int c);
        int k = 0;
        d = 16'hxxxx;
        to = 1'bx;
        c = -1;
        while (!rsp_valid && k < 500) begin
            tick();
            k++;
        end
        if (rsp_valid) begin
            d = rsp_data;
            to = rsp_timeout;
            c = cyc;
        end else begin
            chk("rsp_bound", 32'd0, 32'd1);
        end
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic check_tx(input string tag, input int n, input logic [7:0] e0,
                            input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({tag, "_count"}, tx_q.size(), n);
        for (int i = 0; i < n && i < tx_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, tx_q[i]}, {24'd0, e[i]});
        tx_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_type = '0;
        cmd_address = '0;
        cmd_data_a = '0;
        cmd_data_b = '0;
        cmd_function = '0;
        rx_valid = 1'b0;
        rx_data = '0;
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        reset_n = 1'b1;
        tick();

        // 1: REG_WRITE addr 3 data 0x5A
        issue(2'd0, 4'h3, 8'h5A, 8'h00, 4'h0);
        chk("t1_ready_drop", cmd_ready, 0);
        wait_rsp(r_d, r_to, r_cyc);
        chk("t1_rsp_data", r_d, 16'h0000);
        chk("t1_rsp_to", r_to, 0);
        check_tx("t1_tx", 3, 8'hAA, 8'h03, 8'h5A, 8'h00);

        // 2: REG_READ addr 0xF, reply 0x3C
        issue(2'd1, 4'hF, 8'h00, 8'h00, 4'h0);
        wait_txdone(2);
        tick();
        tick();
        rx_pulse(8'h3C);
        wait_rsp(r_d, r_to, r_cyc);
        chk("t2_rsp_data", r_d, 16'h003C);
        chk("t2_rsp_to", r_to, 0);
        check_tx("t2_tx", 2, 8'hBB, 8'h0F, 8'h00, 8'h00);

        // 4: REG_READ with no reply -> timeout 32 cycles after WAIT_RSP entry
        issue(2'd1, 4'h5, 8'h00, 8'h00, 4'h0);
        wait_txdone(2);
        wait_rsp(r_d, r_to, r_cyc);
        chk("t4_rsp_to", r_to, 1);
        chk("t4_rsp_data", r_d, 16'h0000);
        chk("t4_latency", r_cyc - (fall_cyc + 1), 32);
        check_tx("t4_tx", 2, 8'hBB, 8'h05, 8'h00, 8'h00);
        issue(2'd0, 4'h1, 8'h77, 8'h00, 4'h0);
        wait_rsp(r_d, r_to, r_cyc);
        chk("t4_next_data", r_d, 16'h0000);
        chk("t4_next_to", r_to, 0);
        check_tx("t4_next_tx", 3, 8'hAA, 8'h01, 8'h77, 8'h00);

        // 4b: reply arrives on the expiry cycle and wins
        issue(2'd1, 4'h2, 8'h00, 8'h00, 4'h0);
        wait_txdone(2);
        target = fall_cyc + 32;
        for (int k = 0; k < 200 && cyc < target; k++) tick();
        chk("t4b_align", cyc, target);
        rx_pulse(8'hE7);
        wait_rsp(r_d, r_to, r_cyc);
        chk("t4b_rsp_data", r_d, 16'h00E7);
        chk("t4b_rsp_to", r_to, 0);
        chk("t4b_latency", r_cyc - (fall_cyc + 1), 32);
        check_tx("t4b_tx", 2, 8'hBB, 8'h02, 8'h00, 8'h00);

        // 3: ALU_WITH_OPERANDS, reply LSB first
        issue(2'd2, 4'h0, 8'h12, 8'h34, 4'h2);
        wait_txdone(4);
        tick();
        rx_pulse(8'h78);
        tick();
        rx_pulse(8'h56);
        wait_rsp(r_d, r_to, r_cyc);
        chk("t3_rsp_data", r_d, 16'h5678);
        chk("t3_rsp_to", r_to, 0);
        check_tx("t3_tx", 4, 8'hCC, 8'h12, 8'h34, 8'h02);

        // 5: reset after the second byte, then a clean REG_READ with a stray rx byte
        rsp_before = n_rsp;
        issue(2'd2, 4'h0, 8'hAB, 8'hCD, 4'h1);
        for (int k = 0; k < 200 && tx_q.size() < 2; k++) tick();
        reset_n = 1'b0;
        #1;
        chk("t5_rst_ready", cmd_ready, 1);
        chk("t5_rst_tx_valid", tx_valid, 0);
        chk("t5_rst_tx_data", tx_data, 0);
        chk("t5_rst_rsp_valid", rsp_valid, 0);
        chk("t5_rst_rsp_data", rsp_data, 0);
        chk("t5_rst_rsp_to", rsp_timeout, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tx_q.delete();
        issue(2'd1, 4'h7, 8'h00, 8'h00, 4'h0);
        tick();
        rx_pulse(8'h99);
        wait_txdone(2);
        tick();
        tick();
        rx_pulse(8'h42);
        wait_rsp(r_d, r_to, r_cyc);
        chk("t5_rsp_data", r_d, 16'h0042);
        chk("t5_rsp_to", r_to, 0);
        chk("t5_rsp_count", n_rsp, rsp_before + 1);
        check_tx("t5_tx", 2, 8'hBB, 8'h07, 8'h00, 8'h00);

        // 6: ALU_NO_OPERANDS with cmd_valid pulses while busy
        rsp_before = n_rsp;
        issue(2'd3, 4'h0, 8'h00, 8'h00, 4'hB);
        for (int p = 0; p < 5; p++) begin
            repeat (3) tick();
            cmd_type = 2'd0;
            cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
        end
        wait_txdone(2);
        tick();
        rx_pulse(8'h11);
        tick();
        rx_pulse(8'h22);
        wait_rsp(r_d, r_to, r_cyc);
        chk("t6_rsp_data", r_d, 16'h2211);
        chk("t6_rsp_to", r_to, 0);
        repeat (40) tick();
        chk("t6_rsp_count", n_rsp, rsp_before + 1);
        check_tx("t6_tx", 2, 8'hDD, 8'h0B, 8'h00, 8'h00);

        chk("strobe_while_busy", n_busy_viol, 0);
        chk("double_strobe", n_double, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
